// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and stage-register controls for pipe_hazard_ctrl
// master = pipeline datapath side, slave = the hazard sequencer.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_redirect;
    logic       mem_req;
    logic       dmem_ready;
    logic       stall_pc;
    logic       stall_if_id;
    logic       stall_id_ex;
    logic       stall_ex_mem;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       bubble_mem_wb;
    logic       mem_timeout_err;
    logic [1:0] ctrl_state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_redirect, mem_req, dmem_ready,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, bubble_mem_wb, mem_timeout_err, ctrl_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_redirect, mem_req, dmem_ready,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, bubble_mem_wb, mem_timeout_err, ctrl_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Optional performance counters are enabled with PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    hz
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;

    logic stall_pc_c, stall_if_id_c, stall_id_ex_c, stall_ex_mem_c;
    logic flush_if_id_c, flush_id_ex_c, bubble_c;
    logic load_use;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        err_d          = err_q;
        stall_pc_c     = 1'b0;
        stall_if_id_c  = 1'b0;
        stall_id_ex_c  = 1'b0;
        stall_ex_mem_c = 1'b0;
        flush_if_id_c  = 1'b0;
        flush_id_ex_c  = 1'b0;
        bubble_c       = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.mem_req && !hz.dmem_ready) begin
                    stall_pc_c     = 1'b1;
                    stall_if_id_c  = 1'b1;
                    stall_id_ex_c  = 1'b1;
                    stall_ex_mem_c = 1'b1;
                    bubble_c       = 1'b1;
                    state_d        = MEM_WAIT;
                    wait_cnt_d     = 8'd1;
                end else if (hz.ex_redirect) begin
                    // ID holds a wrong-path instruction, so its load-use hazard is moot
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                end else if (load_use) begin
                    stall_pc_c    = 1'b1;
                    stall_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!hz.dmem_ready) begin
                    stall_pc_c     = 1'b1;
                    stall_if_id_c  = 1'b1;
                    stall_id_ex_c  = 1'b1;
                    stall_ex_mem_c = 1'b1;
                    bubble_c       = 1'b1;
                    if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            ERROR: begin
                stall_pc_c     = 1'b1;
                stall_if_id_c  = 1'b1;
                stall_id_ex_c  = 1'b1;
                stall_ex_mem_c = 1'b1;
                bubble_c       = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Reset wins over every control so nothing is held across the reset edge
        if (rst) begin
            stall_pc_c     = 1'b0;
            stall_if_id_c  = 1'b0;
            stall_id_ex_c  = 1'b0;
            stall_ex_mem_c = 1'b0;
            flush_if_id_c  = 1'b0;
            flush_id_ex_c  = 1'b0;
            bubble_c       = 1'b0;
        end
    end

    assign hz.stall_pc        = stall_pc_c;
    assign hz.stall_if_id     = stall_if_id_c;
    assign hz.stall_id_ex     = stall_id_ex_c;
    assign hz.stall_ex_mem    = stall_ex_mem_c;
    assign hz.flush_if_id     = flush_if_id_c;
    assign hz.flush_id_ex     = flush_id_ex_c;
    assign hz.bubble_mem_wb   = bubble_c;
    assign hz.mem_timeout_err = err_q && !rst;
    assign hz.ctrl_state      = rst ? 2'd0 : state_q;

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_pc_c && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if ((flush_if_id_c || flush_id_ex_c) && (flush_events != {CNT_W{1'b1}}))
                flush_events <= flush_events + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_hazard_ctrl_if hif ();

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .hz           (hif.slave)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, bubble_mem_wb}
    function automatic logic [6:0] ctl();
        return {hif.stall_pc, hif.stall_if_id, hif.stall_id_ex, hif.stall_ex_mem,
                hif.flush_if_id, hif.flush_id_ex, hif.bubble_mem_wb};
    endfunction

    task automatic clear_inputs();
        hif.id_rs1      = 5'd0;
        hif.id_rs2      = 5'd0;
        hif.id_uses_rs1 = 1'b0;
        hif.id_uses_rs2 = 1'b0;
        hif.ex_rd       = 5'd0;
        hif.ex_mem_read = 1'b0;
        hif.ex_redirect = 1'b0;
        hif.mem_req     = 1'b0;
        hif.dmem_ready  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        hif.mem_req = 1'b1;
        hif.ex_redirect = 1'b1;
        #1;
        total++;
        if (ctl() !== 7'b0000000) begin
            $display("FAIL reset_ctl_during_rst got=%b want=%b", ctl(), 7'b0000000); bad++;
        end
        total++;
        if (hif.ctrl_state !== 2'd0) begin
            $display("FAIL reset_state_during_rst got=%0d want=0", hif.ctrl_state); bad++;
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        total++;
        if (ctl() !== 7'b0000000 || hif.mem_timeout_err !== 1'b0 || hif.ctrl_state !== 2'd0) begin
            $display("FAIL reset_after ctl=%b err=%b st=%0d want 0/0/0", ctl(), hif.mem_timeout_err, hif.ctrl_state); bad++;
        end
`ifdef PIPE_HAZARD_PERF_EN
        total++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            $display("FAIL reset_counters stall=%0d flush=%0d want 0/0", stall_cycles, flush_events); bad++;
        end
`endif
    endtask

    task automatic test_load_use();
        do_reset();
        hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5; hif.id_uses_rs2 = 1'b1; hif.id_rs2 = 5'd5;
        #1;
        total++;
        if (ctl() !== 7'b1100010) begin
            $display("FAIL load_use_rs2 got=%b want=%b", ctl(), 7'b1100010); bad++;
        end
        tick();
        hif.ex_mem_read = 1'b0; hif.ex_rd = 5'd0;
        #1;
        total++;
        if (ctl() !== 7'b0000000) begin
            $display("FAIL load_use_bubble got=%b want=%b", ctl(), 7'b0000000); bad++;
        end
        tick();
        hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd0; hif.id_rs2 = 5'd0;
        #1;
        total++;
        if (ctl() !== 7'b0000000) begin
            $display("FAIL load_use_x0 got=%b want=%b", ctl(), 7'b0000000); bad++;
        end
        tick();
        clear_inputs();
        hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd7; hif.id_uses_rs1 = 1'b1; hif.id_rs1 = 5'd7;
        #1;
        total++;
        if (ctl() !== 7'b1100010) begin
            $display("FAIL load_use_rs1 got=%b want=%b", ctl(), 7'b1100010); bad++;
        end
        tick();
        hif.id_uses_rs1 = 1'b0;
        #1;
        total++;
        if (ctl() !== 7'b0000000) begin
            $display("FAIL load_use_unused_rs1 got=%b want=%b", ctl(), 7'b0000000); bad++;
        end
`ifdef PIPE_HAZARD_PERF_EN
        total++;
        if (stall_cycles !== 32'd2 || flush_events !== 32'd2) begin
            $display("FAIL load_use_counters stall=%0d flush=%0d want 2/2", stall_cycles, flush_events); bad++;
        end
`endif
        clear_inputs();
    endtask

    task automatic test_redirect_load_use();
        do_reset();
        hif.ex_redirect = 1'b1;
        hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd9; hif.id_uses_rs1 = 1'b1; hif.id_rs1 = 5'd9;
        #1;
        total++;
        if (ctl() !== 7'b0000110) begin
            $display("FAIL redirect_over_load_use got=%b want=%b", ctl(), 7'b0000110); bad++;
        end
        tick();
        clear_inputs();
        #1;
`ifdef PIPE_HAZARD_PERF_EN
        total++;
        if (flush_events !== 32'd1 || stall_cycles !== 32'd0) begin
            $display("FAIL redirect_counters stall=%0d flush=%0d want 0/1", stall_cycles, flush_events); bad++;
        end
`endif
        total++;
        if (ctl() !== 7'b0000000) begin
            $display("FAIL redirect_release got=%b want=%b", ctl(), 7'b0000000); bad++;
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        hif.mem_req = 1'b1; hif.dmem_ready = 1'b1;
        #1;
        total++;
        if (ctl() !== 7'b0000000) begin
            $display("FAIL mem_first_cycle_ready got=%b want=%b", ctl(), 7'b0000000); bad++;
        end
        tick();
        total++;
        if (hif.ctrl_state !== 2'd0) begin
            $display("FAIL mem_first_cycle_state got=%0d want=0", hif.ctrl_state); bad++;
        end
        hif.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl() !== 7'b1111001 || hif.ctrl_state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                $display("FAIL mem_wait_cycle%0d ctl=%b st=%0d want=%b/%0d", i, ctl(), hif.ctrl_state,
                         7'b1111001, (i == 0) ? 0 : 1); bad++;
            end
            tick();
        end
        hif.dmem_ready = 1'b1;
        #1;
        total++;
        if (ctl() !== 7'b0000000 || hif.ctrl_state !== 2'd1) begin
            $display("FAIL mem_ready_cycle ctl=%b st=%0d want=0000000/1", ctl(), hif.ctrl_state); bad++;
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if (hif.ctrl_state !== 2'd0 || ctl() !== 7'b0000000) begin
            $display("FAIL mem_back_to_run ctl=%b st=%0d want=0000000/0", ctl(), hif.ctrl_state); bad++;
        end
`ifdef PIPE_HAZARD_PERF_EN
        total++;
        if (stall_cycles !== 32'd3 || flush_events !== 32'd0) begin
            $display("FAIL mem_wait_counters stall=%0d flush=%0d want 3/0", stall_cycles, flush_events); bad++;
        end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        hif.mem_req = 1'b1; hif.dmem_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++;
            if (hif.ctrl_state !== ((k < 5) ? 2'd1 : 2'd2) || hif.mem_timeout_err !== (k == 5)) begin
                $display("FAIL timeout_edge%0d st=%0d err=%b want=%0d/%0d", k, hif.ctrl_state,
                         hif.mem_timeout_err, (k < 5) ? 1 : 2, (k == 5) ? 1 : 0); bad++;
            end
        end
        hif.ex_redirect = 1'b1; hif.dmem_ready = 1'b1;
        tick();
        total++;
        if (ctl() !== 7'b1111001 || hif.ctrl_state !== 2'd2 || hif.mem_timeout_err !== 1'b1) begin
            $display("FAIL timeout_held ctl=%b st=%0d err=%b want=1111001/2/1", ctl(), hif.ctrl_state,
                     hif.mem_timeout_err); bad++;
        end
        rst = 1'b1;
        #1;
        total++;
        if (ctl() !== 7'b0000000 || hif.mem_timeout_err !== 1'b0) begin
            $display("FAIL timeout_rst_comb ctl=%b err=%b want=0000000/0", ctl(), hif.mem_timeout_err); bad++;
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        total++;
        if (hif.ctrl_state !== 2'd0 || hif.mem_timeout_err !== 1'b0 || ctl() !== 7'b0000000) begin
            $display("FAIL timeout_recover st=%0d err=%b ctl=%b want=0/0/0000000", hif.ctrl_state,
                     hif.mem_timeout_err, ctl()); bad++;
        end
    endtask

    task automatic test_redirect_in_wait();
        do_reset();
        hif.mem_req = 1'b1; hif.dmem_ready = 1'b0; hif.ex_redirect = 1'b1;
        hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd3; hif.id_uses_rs2 = 1'b1; hif.id_rs2 = 5'd3;
        #1;
        total++;
        if (ctl() !== 7'b1111001) begin
            $display("FAIL triple_event_priority got=%b want=%b", ctl(), 7'b1111001); bad++;
        end
        tick();
        total++;
        if (ctl() !== 7'b1111001) begin
            $display("FAIL redirect_wait_hold got=%b want=%b", ctl(), 7'b1111001); bad++;
        end
        tick();
        hif.dmem_ready = 1'b1;
        #1;
        total++;
        if (ctl() !== 7'b0000000) begin
            $display("FAIL redirect_wait_release got=%b want=%b", ctl(), 7'b0000000); bad++;
        end
        tick();
        hif.mem_req = 1'b0;
        #1;
        total++;
        if (ctl() !== 7'b0000110 || hif.ctrl_state !== 2'd0) begin
            $display("FAIL redirect_after_wait ctl=%b st=%0d want=0000110/0", ctl(), hif.ctrl_state); bad++;
        end
        tick();
        clear_inputs();
        #1;
`ifdef PIPE_HAZARD_PERF_EN
        total++;
        if (stall_cycles !== 32'd2 || flush_events !== 32'd1) begin
            $display("FAIL redirect_wait_counters stall=%0d flush=%0d want 2/1", stall_cycles, flush_events); bad++;
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        hif.mem_req = 1'b1; hif.dmem_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (ctl() !== 7'b0000000 || hif.ctrl_state !== 2'd0 || hif.mem_timeout_err !== 1'b0) begin
            $display("FAIL rst_mid_wait_comb ctl=%b st=%0d err=%b want=0000000/0/0", ctl(),
                     hif.ctrl_state, hif.mem_timeout_err); bad++;
        end
        tick();
        rst = 1'b0;
        hif.dmem_ready = 1'b1;
        #1;
        total++;
        if (hif.ctrl_state !== 2'd0 || ctl() !== 7'b0000000) begin
            $display("FAIL rst_mid_wait_after st=%0d ctl=%b want=0/0000000", hif.ctrl_state, ctl()); bad++;
        end
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_redirect_load_use();
        test_mem_wait();
        test_timeout();
        test_redirect_in_wait();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Consumes hazard information from ID, EX and MEM, plus the data-memory ready handshake.
- Drives hold/flush/bubble controls into the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Replaces per-stage ad-hoc stall logic with one FSM that arbitrates memory wait, control redirect and load-use stalls, and traps a hung data memory.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum consecutive wait cycles on dmem_ready before the error trap; legal range 1..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_redirect  in  1  branch taken or jump resolved in EX
- mem_req  in  1  EX/MEM holds a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID
- stall_id_ex  out  1  hold ID/EX
- stall_ex_mem  out  1  hold EX/MEM
- flush_if_id  out  1  clear IF/ID to NOP on the next edge
- flush_id_ex  out  1  clear ID/EX to NOP (reg_write=0, mem ops=0)
- bubble_mem_wb  out  1  MEM/WB loads a bubble (reg_write=0, jump=0)
- mem_timeout_err  out  1  sticky hang indication
- ctrl_state  out  2  FSM state for debug: RUN=0, MEM_WAIT=1, ERROR=2

## Operation
- FSM states are RUN, MEM_WAIT and ERROR. The wait counter is 8 bits.
- Outputs are combinational from the state and the current inputs (Mealy).
- Events are evaluated in RUN in the priority order below.
- Memory wait (highest priority), when mem_req=1 and dmem_ready=0:
  - stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and bubble_mem_wb are all 1.
  - Both flushes are 0.
  - Next state is MEM_WAIT, and wait_cnt <= 1.
- Redirect, when ex_redirect=1 and there is no memory wait:
  - flush_if_id=1 and flush_id_ex=1.
  - No stalls.
  - Any load-use hazard detected this cycle is ignored, because the ID instruction is on the wrong path.
- Load-use:
  - Hazard condition: ex_mem_read=1 and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
  - Response: stall_pc=1, stall_if_id=1, flush_id_ex=1 for exactly that cycle.
  - The bubble then occupies EX, so the hazard cannot re-fire for the same pair.
- MEM_WAIT:
  - While dmem_ready=0: all four stalls and bubble_mem_wb stay 1, flushes stay 0, and wait_cnt increments.
  - Timeout: if dmem_ready=0 and wait_cnt==MEM_TIMEOUT, next state is ERROR and mem_timeout_err is set.
  - Release: when dmem_ready=1, all controls are 0 in that same cycle and next state is RUN.
  - ex_redirect and load-use inputs are ignored in MEM_WAIT. EX is frozen, so they are re-evaluated in RUN on the following cycle.
- ERROR:
  - All four stalls and bubble_mem_wb are held at 1.
  - mem_timeout_err=1.
  - The block leaves ERROR only on rst.

## Timing
- Reset:
  - While rst=1, every stall, flush and bubble output is 0 and ctrl_state=0.
  - On the next clk edge: state=RUN, wait_cnt=0, mem_timeout_err=0, and the performance counters are cleared.
- Latency: controls are valid in the same cycle as the causing inputs and act on the next clk edge.
- A memory access that completes on its first cycle (mem_req=1 with dmem_ready=1) causes no stall and does not enter MEM_WAIT.
- A memory wait of N cycles freezes the pipeline for exactly N edges.
- Timeout: with MEM_TIMEOUT=M, ERROR is entered on the edge ending the (M+1)-th consecutive not-ready cycle, counting the RUN detection cycle.
- rst asserted in MEM_WAIT or ERROR returns the block to RUN on that edge, with no residual stall.
- Simultaneous memory wait, redirect and load-use: only the memory stall is applied.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - Adds outputs stall_cycles [CNT_W-1:0] and flush_events [CNT_W-1:0].
  - stall_cycles counts every cycle with stall_pc=1.
  - flush_events counts every cycle with flush_if_id=1 or flush_id_ex=1.
  - Both counters saturate at all-ones and clear on rst.
- PIPE_HAZARD_PERF_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 -> exactly 1 cycle of stall_pc=stall_if_id=flush_id_ex=1. With ex_rd=0 instead -> no stall.
- Redirect plus load-use in the same cycle -> flush_if_id=flush_id_ex=1, stall_pc=0. With PERF: flush_events increments by 1.
- Memory wait: mem_req=1, dmem_ready low for 3 cycles then high -> stalls and bubble_mem_wb=1 for 3 cycles, 0 on the ready cycle, state back to RUN. With PERF: stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> ERROR on the 5th edge, mem_timeout_err=1, stalls held. Asserting rst -> RUN, err=0.
- Redirect during MEM_WAIT: ex_redirect=1 throughout a 2-cycle wait -> no flush while waiting; flush on the first RUN cycle after dmem_ready.
- Reset mid-wait: rst asserted in the 2nd wait cycle -> all outputs 0 that cycle, state=RUN and wait_cnt=0 after the edge.
